// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave front-end for the SPI-to-RAM wrapper.
// Deserialises CMD_W+DATA_W bit frames from the master into rx_data with a
// one-cycle rx_valid strobe, serialises RAM read data on MISO after the
// tx_valid handshake, tracks a pending read address and flags aborted frames.
module spi_slave_param #(
  parameter int DATA_W    = 8,
  parameter int CMD_W     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    SS_n,
  input  logic                    MOSI,
  output logic                    MISO,
  output logic [CMD_W+DATA_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output logic                    rd_addr_pending,
  output logic                    frame_err
);

  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  // Counter value seen on the edge that samples the last frame bit, and the
  // value reached once the last TX bit has been held for a full cycle.
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_TX,
    SEND,
    DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [FRAME_W-1:0] rx_shift;
  logic [FRAME_W-1:0] rx_shift_next;
  logic [DATA_W-1:0]  tx_shift;
  logic [CNT_W-1:0]   bit_cnt;

  // Per-edge control decisions produced by the next-state logic.
  logic shift_in;   // sample MOSI into the RX shifter
  logic rx_done;    // this edge samples the final frame bit
  logic abort;      // SS_n rose before the frame/transmission completed
  logic tx_load;    // tx_valid accepted: load shifter, drive first bit
  logic tx_step;    // drive the next TX bit

  // Insert one received bit; MSB-first fills from the right so bit 1 ends up
  // at the top, LSB-first fills from the left so bit 1 ends up at bit 0.
  function automatic logic [FRAME_W-1:0] rx_insert(input logic [FRAME_W-1:0] cur,
                                                   input logic              bit_in);
    if (MSB_FIRST != 0) begin
      return {cur[FRAME_W-2:0], bit_in};
    end else begin
      return {bit_in, cur[FRAME_W-1:1]};
    end
  endfunction

  // Bit of a TX word that goes out next on MISO.
  function automatic logic tx_head(input logic [DATA_W-1:0] word);
    if (MSB_FIRST != 0) begin
      return word[DATA_W-1];
    end else begin
      return word[0];
    end
  endfunction

  // Drop the bit just sent so the following one becomes the head.
  function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] word);
    if (MSB_FIRST != 0) begin
      return {word[DATA_W-2:0], 1'b0};
    end else begin
      return {1'b0, word[DATA_W-1:1]};
    end
  endfunction

  assign rx_shift_next = rx_insert(rx_shift, MOSI);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-edge control; frame completion outranks SS_n rising.
  always_comb begin
    next_state = state;
    shift_in   = 1'b0;
    rx_done    = 1'b0;
    abort      = 1'b0;
    tx_load    = 1'b0;
    tx_step    = 1'b0;
    case (state)
      IDLE: begin
        if (!SS_n) begin
          next_state = CHK_CMD;
        end
      end
      CHK_CMD: begin
        if (SS_n) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          shift_in = 1'b1;
          if (!MOSI) begin
            next_state = WRITE;
          end else if (rd_addr_pending) begin
            next_state = READ_DATA;
          end else begin
            next_state = READ_ADD;
          end
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bit_cnt == RX_LAST) begin
          shift_in   = 1'b1;
          rx_done    = 1'b1;
          next_state = (state == READ_DATA) ? WAIT_TX : DONE;
        end else if (SS_n) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          shift_in = 1'b1;
        end
      end
      WAIT_TX: begin
        if (SS_n) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else if (tx_valid) begin
          tx_load    = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (bit_cnt == TX_LAST) begin
          next_state = DONE;
        end else if (SS_n) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          tx_step = 1'b1;
        end
      end
      DONE: begin
        if (SS_n) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Receive path: shifter, completed-frame register and status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift        <= '0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      frame_err       <= 1'b0;
      rd_addr_pending <= 1'b0;
    end else begin
      rx_valid  <= rx_done;
      frame_err <= abort;
      if (next_state == IDLE) begin
        rx_shift <= '0;
      end else if (shift_in) begin
        rx_shift <= rx_shift_next;
      end
      if (rx_done) begin
        rx_data <= rx_shift_next;
        if (state == READ_ADD) begin
          rd_addr_pending <= 1'b1;
        end else if (state == READ_DATA) begin
          rd_addr_pending <= 1'b0;
        end
      end
    end
  end

  // Shared bit counter: frame bits while receiving, sent bits while sending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (next_state == IDLE) begin
      bit_cnt <= '0;
    end else if (tx_load) begin
      bit_cnt <= CNT_ONE;
    end else if (shift_in || tx_step) begin
      bit_cnt <= bit_cnt + CNT_ONE;
    end
  end

  // Transmit path: MISO is registered and idles at 0 outside SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
      MISO     <= 1'b0;
    end else begin
      if (tx_load) begin
        MISO     <= tx_head(tx_data);
        tx_shift <= tx_advance(tx_data);
      end else if (tx_step) begin
        MISO     <= tx_head(tx_shift);
        tx_shift <= tx_advance(tx_shift);
      end else begin
        MISO <= 1'b0;
        if (next_state == IDLE) begin
          tx_shift <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: directed bench for spi_slave_param.
// dut_a uses the default configuration (DATA_W=8, CMD_W=2, MSB first);
// dut_b uses DATA_W=4, CMD_W=1, LSB first.
module tb_spi_slave_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a signals
  logic       rst_a, ss_a, mosi_a, miso_a, rxv_a, pend_a, ferr_a, txv_a;
  logic [9:0] rxd_a;
  logic [7:0] txd_a;

  // dut_b signals
  logic       rst_b, ss_b, mosi_b, miso_b, rxv_b, pend_b, ferr_b, txv_b;
  logic [4:0] rxd_b;
  logic [3:0] txd_b;

  int checks   = 0;
  int failures = 0;

  spi_slave_param dut_a (
    .clk             (clk),
    .rst             (rst_a),
    .SS_n            (ss_a),
    .MOSI            (mosi_a),
    .MISO            (miso_a),
    .rx_data         (rxd_a),
    .rx_valid        (rxv_a),
    .tx_data         (txd_a),
    .tx_valid        (txv_a),
    .rd_addr_pending (pend_a),
    .frame_err       (ferr_a)
  );

  spi_slave_param #(
    .DATA_W    (4),
    .CMD_W     (1),
    .MSB_FIRST (0)
  ) dut_b (
    .clk             (clk),
    .rst             (rst_b),
    .SS_n            (ss_b),
    .MOSI            (mosi_b),
    .MISO            (miso_b),
    .rx_data         (rxd_b),
    .rx_valid        (rxv_b),
    .tx_data         (txd_b),
    .tx_valid        (txv_b),
    .rd_addr_pending (pend_b),
    .frame_err       (ferr_b)
  );

  typedef struct {
    logic       ss_n;
    logic       mosi;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       e_rx_valid;
    logic [9:0] e_rx_data;
    logic       e_miso;
    logic       e_pend;
    logic       e_ferr;
  } vec_t;

  vec_t vecs[$];

  function automatic void push(input logic ss, input logic mosi, input logic txv,
                               input logic [7:0] txd, input logic erxv,
                               input logic [9:0] erxd, input logic emiso,
                               input logic epend, input logic eferr);
    vec_t v;
    v.ss_n       = ss;
    v.mosi       = mosi;
    v.tx_valid   = txv;
    v.tx_data    = txd;
    v.e_rx_valid = erxv;
    v.e_rx_data  = erxd;
    v.e_miso     = emiso;
    v.e_pend     = epend;
    v.e_ferr     = eferr;
    vecs.push_back(v);
  endfunction

  // Ten bit rows of one frame, sent first-bit-first from bits[9]; the
  // completed value and pending flag show up only after the last bit.
  function automatic void push_frame(input logic [9:0] bits, input logic [9:0] prev_data,
                                     input logic prev_pend, input logic [9:0] new_data,
                                     input logic new_pend);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        push(1'b0, bits[9-i], 1'b0, 8'h00, 1'b1, new_data, 1'b0, new_pend, 1'b0);
      end else begin
        push(1'b0, bits[9-i], 1'b0, 8'h00, 1'b0, prev_data, 1'b0, prev_pend, 1'b0);
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive n frame bits into dut_a, first bit taken from bits[9].
  task automatic a_bits(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      mosi_a = bits[9-i];
      step();
    end
  endtask

  // Full selected frame on dut_a followed by a deselect.
  task automatic a_frame(input logic [9:0] bits, input logic [9:0] exp_data,
                         input logic exp_pend, input string name);
    ss_a = 1'b0;
    step();
    a_bits(bits, 10);
    chk({name, " rx_valid"}, rxv_a, 1);
    chk({name, " rx_data"}, rxd_a, exp_data);
    chk({name, " pending"}, pend_a, exp_pend);
    ss_a   = 1'b1;
    mosi_a = 1'b0;
    step();
    chk({name, " rx_valid one cycle"}, rxv_a, 0);
  endtask

  initial begin
    logic [7:0] seq_c3;
    logic [7:0] seq_a5;
    logic [4:0] fb;

    // ---------------- vector table for dut_a ----------------
    seq_c3 = 8'b1100_0011;
    push(1, 0, 0, 8'h00, 0, 10'h000, 0, 0, 0);               // idle
    push(0, 0, 0, 8'h00, 0, 10'h000, 0, 0, 0);               // select
    push_frame(10'b00_1010_0101, 10'h000, 0, 10'h0A5, 0);    // write
    push(0, 1, 0, 8'h00, 0, 10'h0A5, 0, 0, 0);               // DONE ignores MOSI
    push(1, 0, 0, 8'h00, 0, 10'h0A5, 0, 0, 0);               // back to IDLE
    push(0, 0, 0, 8'h00, 0, 10'h0A5, 0, 0, 0);               // select
    push_frame(10'b10_0000_0011, 10'h0A5, 0, 10'h203, 1);    // read address
    push(1, 0, 0, 8'h00, 0, 10'h203, 0, 1, 0);
    push(0, 0, 0, 8'h00, 0, 10'h203, 0, 1, 0);               // select
    push_frame(10'b11_0000_0000, 10'h203, 1, 10'h300, 0);    // read data
    push(0, 0, 0, 8'hC3, 0, 10'h300, 0, 0, 0);               // WAIT_TX, no valid yet
    push(0, 0, 1, 8'hC3, 0, 10'h300, seq_c3[7], 0, 0);       // tx_valid taken
    for (int i = 1; i < 8; i++) begin
      push(0, 0, 1, 8'h00, 0, 10'h300, seq_c3[7-i], 0, 0);   // tx inputs ignored in SEND
    end
    push(0, 0, 0, 8'h00, 0, 10'h300, 0, 0, 0);               // MISO back to 0
    push(0, 1, 0, 8'h00, 0, 10'h300, 0, 0, 0);               // extra DONE clock
    push(1, 0, 0, 8'h00, 0, 10'h300, 0, 0, 0);               // IDLE

    // ---------------- reset ----------------
    rst_a = 0; rst_b = 0;
    ss_a = 1; mosi_a = 0; txv_a = 0; txd_a = 8'h00;
    ss_b = 1; mosi_b = 0; txv_b = 0; txd_b = 4'h0;
    #1;
    rst_a = 1; rst_b = 1;
    #1;
    chk("reset a miso", miso_a, 0);
    chk("reset a rx_valid", rxv_a, 0);
    chk("reset a rx_data", rxd_a, 0);
    chk("reset a pending", pend_a, 0);
    chk("reset a frame_err", ferr_a, 0);
    chk("reset b miso", miso_b, 0);
    chk("reset b rx_data", rxd_b, 0);
    chk("reset b pending", pend_b, 0);
    step();
    rst_a = 0; rst_b = 0;

    // ---------------- table-driven run ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      ss_a   = vecs[i].ss_n;
      mosi_a = vecs[i].mosi;
      txv_a  = vecs[i].tx_valid;
      txd_a  = vecs[i].tx_data;
      step();
      chk($sformatf("vec%0d rx_valid", i), rxv_a, vecs[i].e_rx_valid);
      chk($sformatf("vec%0d rx_data", i), rxd_a, vecs[i].e_rx_data);
      chk($sformatf("vec%0d miso", i), miso_a, vecs[i].e_miso);
      chk($sformatf("vec%0d pending", i), pend_a, vecs[i].e_pend);
      chk($sformatf("vec%0d frame_err", i), ferr_a, vecs[i].e_ferr);
    end
    txv_a = 0;

    // ---------------- abort after 5 write bits ----------------
    ss_a = 0;
    step();
    a_bits(10'b00101_00000, 5);
    ss_a   = 1;
    mosi_a = 0;
    step();
    chk("abort frame_err", ferr_a, 1);
    chk("abort rx_valid", rxv_a, 0);
    chk("abort rx_data kept", rxd_a, 10'h300);
    chk("abort miso", miso_a, 0);
    step();
    chk("abort frame_err one cycle", ferr_a, 0);
    a_frame(10'b01_1100_0011, 10'h1C3, 0, "after abort");

    // ---------------- completion and SS_n rise on the same edge ----------------
    ss_a = 0;
    step();
    a_bits(10'b01_0011_1100, 9);
    ss_a   = 1;
    mosi_a = 1'b0;
    step();
    chk("same edge rx_valid", rxv_a, 1);
    chk("same edge frame_err", ferr_a, 0);
    chk("same edge rx_data", rxd_a, 10'h13C);
    step();
    chk("same edge later frame_err", ferr_a, 0);
    chk("same edge later rx_valid", rxv_a, 0);

    // ---------------- reset in the middle of SEND ----------------
    a_frame(10'b10_0001_0000, 10'h210, 1, "rst rd addr");
    ss_a = 0;
    step();
    a_bits(10'b11_0000_0000, 10);
    chk("rst rd data rx_data", rxd_a, 10'h300);
    txv_a = 1;
    txd_a = 8'hE0;
    step();
    txv_a = 0;
    chk("rst tx bit0", miso_a, 1);
    step();
    chk("rst tx bit1", miso_a, 1);
    step();
    chk("rst tx bit2", miso_a, 1);
    #2;
    rst_a = 1;
    ss_a  = 1;
    #1;
    chk("mid-send rst miso", miso_a, 0);
    chk("mid-send rst rx_valid", rxv_a, 0);
    chk("mid-send rst pending", pend_a, 0);
    chk("mid-send rst rx_data", rxd_a, 0);
    step();
    rst_a = 0;
    a_frame(10'b00_0101_1010, 10'h05A, 0, "post rst write");

    // pending flag cleared by reset without a clock
    a_frame(10'b10_0000_0111, 10'h207, 1, "pend rd addr");
    #2;
    rst_a = 1;
    #1;
    chk("rst clears pending", pend_a, 0);
    step();
    rst_a = 0;

    // ---------------- WAIT_TX hold then 0xA5 ----------------
    a_frame(10'b10_1111_0000, 10'h2F0, 1, "hold rd addr");
    ss_a = 0;
    step();
    a_bits(10'b11_0000_0001, 10);
    chk("hold rd data rx_valid", rxv_a, 1);
    chk("hold rd data rx_data", rxd_a, 10'h301);
    chk("hold rd data pending", pend_a, 0);
    txv_a = 0;
    txd_a = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("hold wait%0d miso", i), miso_a, 0);
    end
    seq_a5 = 8'b1010_0101;
    txv_a  = 1;
    txd_a  = 8'hA5;
    step();
    txv_a = 0;
    txd_a = 8'h00;
    chk("hold tx bit0", miso_a, seq_a5[7]);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("hold tx bit%0d", i), miso_a, seq_a5[7-i]);
    end
    step();
    chk("hold tx end miso", miso_a, 0);
    ss_a = 1;
    step();

    // ---------------- dut_b: LSB first, DATA_W=4, CMD_W=1 ----------------
    ss_b = 0;
    step();
    fb = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      mosi_b = fb[4-i];
      step();
    end
    chk("lsb rd addr rx_valid", rxv_b, 1);
    chk("lsb rd addr rx_data", rxd_b, 5'b01101);
    chk("lsb rd addr pending", pend_b, 1);
    ss_b = 1;
    mosi_b = 0;
    step();
    ss_b = 0;
    step();
    fb = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      mosi_b = fb[4-i];
      step();
    end
    chk("lsb rd data rx_data", rxd_b, 5'b00001);
    chk("lsb rd data pending", pend_b, 0);
    txv_b = 1;
    txd_b = 4'h6;
    step();
    txv_b = 0;
    txd_b = 4'h0;
    chk("lsb tx bit0", miso_b, 0);
    step();
    chk("lsb tx bit1", miso_b, 1);
    step();
    chk("lsb tx bit2", miso_b, 1);
    step();
    chk("lsb tx bit3", miso_b, 0);
    step();
    chk("lsb tx end miso", miso_b, 0);
    chk("lsb frame_err", ferr_b, 0);
    ss_b = 1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
